// File: rtl/nd_4to1_rr_pkg.sv
// rtl/nd_4to1_rr_pkg.sv - shared sizes, types and helpers for the 4-to-1 round-robin merger
//
// Purpose: default message geometry, requester count, init/run state type and the
//          round-robin pointer advance used by the merger and its channel interface.
// Ports:   none (package).

package nd_4to1_rr_pkg;

    localparam int NS_MESSAGE_FIFO_SIZE = 4;
    localparam int NS_ADDRESS_SIZE      = 8;
    localparam int NS_DATA_SIZE         = 16;
    localparam int NS_NUM_RCV           = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Next pointer after a grant: the requester just served drops to lowest priority.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/nd_4to1_rr_if.sv
// rtl/nd_4to1_rr_if.sv - channel bundle between four producers, the merger and one consumer
//
// Purpose: groups the outgoing snd0 channel, the four incoming rcvK channels and ready.
// Ports (modports):
//   slave  - the merger: drives ready, snd0_src/dst/dat/req, rcv_ack; reads snd0_ack, rcv_*.
//   master - the surrounding producers/consumer: the mirror image of slave.

interface nd_4to1_rr_if
    import nd_4to1_rr_pkg::*;
#(
    parameter int ASZ = NS_ADDRESS_SIZE,
    parameter int DSZ = NS_DATA_SIZE
) ();

    logic                                 ready;

    logic [ASZ-1:0]                       snd0_src;
    logic [ASZ-1:0]                       snd0_dst;
    logic [DSZ-1:0]                       snd0_dat;
    logic                                 snd0_req;
    logic                                 snd0_ack;

    logic [NS_NUM_RCV-1:0][ASZ-1:0]       rcv_src;
    logic [NS_NUM_RCV-1:0][ASZ-1:0]       rcv_dst;
    logic [NS_NUM_RCV-1:0][DSZ-1:0]       rcv_dat;
    logic [NS_NUM_RCV-1:0]                rcv_req;
    logic [NS_NUM_RCV-1:0]                rcv_ack;

    modport slave (
        output ready,
        output snd0_src, snd0_dst, snd0_dat, snd0_req,
        input  snd0_ack,
        input  rcv_src, rcv_dst, rcv_dat, rcv_req,
        output rcv_ack
    );

    modport master (
        input  ready,
        input  snd0_src, snd0_dst, snd0_dat, snd0_req,
        output snd0_ack,
        output rcv_src, rcv_dst, rcv_dat, rcv_req,
        input  rcv_ack
    );

endinterface

// File: rtl/nd_rr_pick4.sv
// rtl/nd_rr_pick4.sv - combinational 4-way round-robin pick
//
// Purpose: selects the first eligible requester scanning ptr, ptr+1, ... (mod 4).
// Ports:
//   elig_i       in   4  eligible requesters
//   ptr_i        in   2  highest-priority index
//   grant_vld_o  out  1  some requester is eligible
//   grant_idx_o  out  2  index of the chosen requester

module nd_rr_pick4
    import nd_4to1_rr_pkg::*;
(
    input  logic [NS_NUM_RCV-1:0] elig_i,
    input  logic [1:0]            ptr_i,
    output logic                  grant_vld_o,
    output logic [1:0]            grant_idx_o
);

    // Scan from the farthest offset back to ptr so the nearest eligible one wins.
    always_comb begin
        grant_vld_o = 1'b0;
        grant_idx_o = ptr_i;
        for (int i = NS_NUM_RCV - 1; i >= 0; i--) begin
            if (elig_i[ptr_i + 2'(i)]) begin
                grant_vld_o = 1'b1;
                grant_idx_o = ptr_i + 2'(i);
            end
        end
    end

endmodule

// File: rtl/nd_4to1_rr.sv
// rtl/nd_4to1_rr.sv - round-robin merger of four 4-phase channels through one message FIFO
//
// Purpose: grants at most one of four incoming req/ack channels per cycle (round robin),
//          buffers the message in an FSZ-deep FIFO and replays messages in grant order
//          on the single outgoing 4-phase channel.
// Ports:
//   i_clk   in   1  clock
//   reset   in   1  synchronous, active-high; only clears ready, the next edge initialises
//   bus     slave modport of nd_4to1_rr_if (ready, snd0_*, rcvK_*)

module nd_4to1_rr
    import nd_4to1_rr_pkg::*;
#(
    parameter int FSZ = NS_MESSAGE_FIFO_SIZE,
    parameter int ASZ = NS_ADDRESS_SIZE,
    parameter int DSZ = NS_DATA_SIZE
) (
    input  logic          i_clk,
    input  logic          reset,
    nd_4to1_rr_if.slave   bus
);

    localparam int AW = $clog2(FSZ);
    localparam int MW = 2 * ASZ + DSZ;

    logic [MW-1:0]         mem_q [FSZ];

    state_t                state_q, state_d;
    logic [AW-1:0]         head_q, head_d;
    logic [AW-1:0]         tail_q, tail_d;
    logic [AW:0]           count_q, count_d;
    logic [1:0]            ptr_q, ptr_d;
    logic [NS_NUM_RCV-1:0] ack_q, ack_d;
    logic                  snd_req_q, snd_req_d;
    logic [ASZ-1:0]        snd_src_q, snd_src_d;
    logic [ASZ-1:0]        snd_dst_q, snd_dst_d;
    logic [DSZ-1:0]        snd_dat_q, snd_dat_d;

    logic                  running;
    logic                  full;
    logic                  empty;
    logic [NS_NUM_RCV-1:0] elig;
    logic                  gnt_vld;
    logic [1:0]            gnt_idx;
    logic                  push;
    logic                  pop;
    logic [MW-1:0]         push_msg;
    logic [MW-1:0]         tail_msg;

    assign running  = (state_q == ST_RUN);
    assign full     = (count_q == (AW+1)'(FSZ));
    assign empty    = (count_q == '0);
    assign elig     = bus.rcv_req & ~ack_q;

    nd_rr_pick4 u_pick (
        .elig_i      (elig),
        .ptr_i       (ptr_q),
        .grant_vld_o (gnt_vld),
        .grant_idx_o (gnt_idx)
    );

    // Full is taken from the pre-edge count, so a same-cycle pop never frees a slot for a push.
    assign push     = running & gnt_vld & ~full;
    // A new load waits for the consumer to drop ack from the previous message.
    assign pop      = running & ~empty & ~snd_req_q & ~bus.snd0_ack;
    assign push_msg = {bus.rcv_src[gnt_idx], bus.rcv_dst[gnt_idx], bus.rcv_dat[gnt_idx]};
    assign tail_msg = mem_q[tail_q];

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        ptr_d     = ptr_q;
        ack_d     = ack_q;
        snd_req_d = snd_req_q;
        snd_src_d = snd_src_q;
        snd_dst_d = snd_dst_q;
        snd_dat_d = snd_dat_q;

        if (!running) begin
            // Init cycle: everything cleared, no transfers.
            state_d   = ST_RUN;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            ptr_d     = '0;
            ack_d     = '0;
            snd_req_d = 1'b0;
            snd_src_d = '0;
            snd_dst_d = '0;
            snd_dat_d = '0;
        end else begin
            for (int k = 0; k < NS_NUM_RCV; k++) begin
                if (!bus.rcv_req[k] && ack_q[k]) begin
                    ack_d[k] = 1'b0;
                end
            end

            // A granted input has ack low, so this never collides with the release above.
            if (push) begin
                ack_d[gnt_idx] = 1'b1;
                head_d         = head_q + 1'b1;
                ptr_d          = rr_next(gnt_idx);
            end

            if (pop) begin
                {snd_src_d, snd_dst_d, snd_dat_d} = tail_msg;
                snd_req_d = 1'b1;
                tail_d    = tail_q + 1'b1;
            end else if (snd_req_q && bus.snd0_ack) begin
                snd_req_d = 1'b0;
            end

            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Reset only drops out of run state; the following edge performs the init.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            snd_req_q <= snd_req_d;
            snd_src_q <= snd_src_d;
            snd_dst_q <= snd_dst_d;
            snd_dat_q <= snd_dat_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!reset && push) begin
            mem_q[head_q] <= push_msg;
        end
    end

    assign bus.ready    = running;
    assign bus.snd0_src = snd_src_q;
    assign bus.snd0_dst = snd_dst_q;
    assign bus.snd0_dat = snd_dat_q;
    assign bus.snd0_req = snd_req_q;
    assign bus.rcv_ack  = ack_q;

endmodule

// File: tb/tb_nd_4to1_rr.sv
// tb/tb_nd_4to1_rr.sv - scoreboard bench for the 4-to-1 round-robin merger

module tb_nd_4to1_rr;

    localparam int FSZ = 4;
    localparam int ASZ = 8;
    localparam int DSZ = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nd_4to1_rr_if #(.ASZ(ASZ), .DSZ(DSZ)) bus ();

    nd_4to1_rr #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ)) dut (
        .i_clk (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          n_rx    = 0;
    bit          auto_ack = 1'b0;
    logic        prev_req = 1'b0;
    logic [31:0] sb [$];
    int          ack_cyc [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: 4-phase ack simply follows req when enabled.
    always @(posedge clk) begin
        #2;
        bus.snd0_ack = auto_ack & (bus.snd0_req === 1'b1);
    end

    // Monitor: every newly loaded outgoing message is compared with the scoreboard head.
    always @(negedge clk) begin
        if (bus.snd0_req === 1'b1 && !prev_req) begin
            n_rx <= n_rx + 1;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got %h, required no message",
                         {bus.snd0_src, bus.snd0_dst, bus.snd0_dat});
            end else begin
                check("sb_msg", {bus.snd0_src, bus.snd0_dst, bus.snd0_dat}, sb.pop_front());
            end
        end
        prev_req <= (bus.snd0_req === 1'b1);
    end

    // Called just after a negedge; returns just after a negedge.
    task automatic send(input int k, input logic [31:0] m, input int lim, output bit ok);
        bit got;
        bus.rcv_src[k] = m[31:24];
        bus.rcv_dst[k] = m[23:16];
        bus.rcv_dat[k] = m[15:0];
        bus.rcv_req[k] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < lim && !got; i++) begin
            @(negedge clk);
            if (bus.rcv_ack[k] === 1'b1) got = 1'b1;
        end
        ok = got;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_ack%0d: ack 0 after %0d cycles, required 1", k, lim);
        end
        ack_cyc[k] = cyc;
        bus.rcv_req[k] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < lim && !got; i++) begin
            @(negedge clk);
            if (bus.rcv_ack[k] === 1'b0) got = 1'b1;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_release%0d: ack 1 after %0d cycles, required 0", k, lim);
        end
    endtask

    task automatic do_reset();
        bus.rcv_req = '0;
        auto_ack    = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        check("reset_ready", bus.ready, 1'b0);
        @(negedge clk);
        check("init_ready", bus.ready, 1'b1);
        check("init_snd0_req", bus.snd0_req, 1'b0);
        check("init_acks", bus.rcv_ack, 4'b0000);
        check("init_snd0_fields", {bus.snd0_src, bus.snd0_dst, bus.snd0_dat}, 32'h0);
    endtask

    task automatic drain(input string name, input int lim);
        for (int i = 0; i < lim && sb.size() != 0; i++) @(negedge clk);
        check(name, sb.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          ok;
        bit          got;
        int          cnt0;
        int          cnt1;
        int          rx0;
        logic [31:0] m;

        reset       = 1'b1;
        bus.rcv_req = '0;
        bus.rcv_src = '0;
        bus.rcv_dst = '0;
        bus.rcv_dat = '0;
        do_reset();

        // 1 Single message from rcv2.
        sb.push_back({8'd1, 8'd3, 16'd5});
        bus.rcv_src[2] = 8'd1;
        bus.rcv_dst[2] = 8'd3;
        bus.rcv_dat[2] = 16'd5;
        bus.rcv_req[2] = 1'b1;
        @(negedge clk);
        check("t1_ack_rise", bus.rcv_ack[2], 1'b1);
        check("t1_snd_req_early", bus.snd0_req, 1'b0);
        bus.rcv_req[2] = 1'b0;
        @(negedge clk);
        check("t1_snd_req", bus.snd0_req, 1'b1);
        check("t1_msg", {bus.snd0_src, bus.snd0_dst, bus.snd0_dat}, {8'd1, 8'd3, 16'd5});
        check("t1_ack_release", bus.rcv_ack[2], 1'b0);
        auto_ack = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            if (bus.snd0_req === 1'b0) got = 1'b1;
        end
        check("t1_snd_req_fall", got, 1'b1);

        // 2 Burst with ptr back at 0.
        do_reset();
        auto_ack = 1'b1;
        for (int k = 0; k < 4; k++) sb.push_back({8'(k), 8'(k + 4), 16'h0200 + 16'(k)});
        fork
            begin bit o; send(0, {8'd0, 8'd4, 16'h0200}, 10, o); end
            begin bit o; send(1, {8'd1, 8'd5, 16'h0201}, 10, o); end
            begin bit o; send(2, {8'd2, 8'd6, 16'h0202}, 10, o); end
            begin bit o; send(3, {8'd3, 8'd7, 16'h0203}, 10, o); end
        join
        check("t2_order1", ack_cyc[1] - ack_cyc[0], 1);
        check("t2_order2", ack_cyc[2] - ack_cyc[0], 2);
        check("t2_order3", ack_cyc[3] - ack_cyc[0], 3);
        drain("t2_drain", 40);

        // 3 Fairness: expected merge order alternates 0,1,0,1...
        for (int i = 0; i < 10; i++) begin
            sb.push_back({8'd0, 8'(i), 16'h3000 + 16'(i)});
            sb.push_back({8'd1, 8'(i), 16'h3100 + 16'(i)});
        end
        cnt0 = 0;
        cnt1 = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    bit o;
                    send(0, {8'd0, 8'(i), 16'h3000 + 16'(i)}, 20, o);
                    if (o) cnt0++;
                end
            end
            begin
                for (int j = 0; j < 10; j++) begin
                    bit o;
                    send(1, {8'd1, 8'(j), 16'h3100 + 16'(j)}, 20, o);
                    if (o) cnt1++;
                end
            end
        join
        check("t3_cnt0", cnt0, 10);
        check("t3_cnt1", cnt1, 10);
        drain("t3_drain", 80);

        // 4 Full: output register plus four FIFO slots absorb five messages.
        auto_ack = 1'b0;
        for (int i = 0; i < 6; i++) sb.push_back({8'h40, 8'(i), 16'h4000 + 16'(i)});
        for (int i = 0; i < 5; i++) send(0, {8'h40, 8'(i), 16'h4000 + 16'(i)}, 10, ok);
        bus.rcv_src[0] = 8'h40;
        bus.rcv_dst[0] = 8'd5;
        bus.rcv_dat[0] = 16'h4005;
        bus.rcv_req[0] = 1'b1;
        repeat (5) @(negedge clk);
        check("t4_sixth_blocked", bus.rcv_ack[0], 1'b0);
        auto_ack = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            if (bus.snd0_req === 1'b0) got = 1'b1;
        end
        check("t4_handshake_done", got, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 2 && !got; i++) begin
            @(negedge clk);
            if (bus.rcv_ack[0] === 1'b1) got = 1'b1;
        end
        check("t4_sixth_acked", got, 1'b1);
        bus.rcv_req[0] = 1'b0;
        @(negedge clk);
        drain("t4_drain", 60);

        // 5 Reset with three messages buffered: they must never appear.
        auto_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb.push_back({8'h50, 8'(i), 16'h5000 + 16'(i)});
            send(0, {8'h50, 8'(i), 16'h5000 + 16'(i)}, 10, ok);
        end
        do_reset();
        auto_ack = 1'b1;
        sb.push_back({8'h5a, 8'h5b, 16'h5ccc});
        send(3, {8'h5a, 8'h5b, 16'h5ccc}, 10, ok);
        drain("t5_drain", 20);

        // 6 Sustained traffic around count=3 with simultaneous push and pop.
        rx0 = n_rx;
        auto_ack = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == 4) auto_ack = 1'b1;
            m = $urandom;
            sb.push_back(m);
            send(i % 4, m, 20, ok);
        end
        drain("t6_drain", 400);
        check("t6_rx_count", n_rx - rx0, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
